// File: rtl/uart_rx_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : uart_rx_fifo_pkg
//  Brief   : Shared types, frame-format constants and helpers for the
//            uart_rx_fifo receiver (8N1 framing, receiver state encoding).
//  Revision: 1.0 - initial release
// ============================================================================
package uart_rx_fifo_pkg;

  // Frame format: 8 data bits, LSB first, one stop bit, no parity.
  localparam int DATA_BITS           = 8;
  // Default floor applied to the CSR bit period (clock cycles per bit).
  localparam int CLK_DIV_MIN_DEFAULT = 4;
  // Width of the baud down-counter and of the clk_div CSR field.
  localparam int DIV_W               = 16;

  // Receiver sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_t;

  // Bit period actually used: the CSR value, but never below the floor.
  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] raw,
                                                input logic [DIV_W-1:0] floor_val);
    return (raw < floor_val) ? floor_val : raw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : rx_byte_fifo
//  Brief   : Small first-word-fall-through FIFO holding received bytes.
//            Reports occupancy and flags pushes rejected because it is full.
//  Revision: 1.0 - initial release
// ============================================================================
module rx_byte_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     resetb,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     dropped
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;

  logic empty;
  logic full;
  logic do_pop;
  logic do_push;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  // A pop on an empty FIFO is ignored.
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO only succeeds when a pop frees a slot in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign dropped = push & full & ~do_pop;

  assign valid   = ~empty;
  assign count   = count_q;
  // Head is forced to zero while empty so the output is clean after reset.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // Storage array: written on accepted pushes, no reset needed since
  // entries are only visible once the count covers them.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of 2).
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : uart_rx_fifo
//  Brief   : 8N1 UART receiver feeding a byte FIFO read over CSRs. Holds the
//            rx synchroniser, frame sequencer, baud counter and sticky
//            framing-error / overflow flags; irq follows FIFO non-empty.
//  Revision: 1.0 - initial release
// ============================================================================
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int CLK_DIV_MIN = CLK_DIV_MIN_DEFAULT
) (
  input  logic                   clock,
  input  logic                   resetb,
  input  logic                   rx,
  input  logic [DIV_W-1:0]       clk_div,
  input  logic                   rd_en,
  input  logic                   err_clr,
  output logic [7:0]             rd_data,
  output logic                   rd_valid,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   frame_err,
  output logic                   overflow,
  output logic                   busy,
  output logic                   irq
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  logic                 rx_meta;
  logic                 rxs;
  rx_state_t            state;
  logic [DIV_W-1:0]     cnt;
  logic [DIV_W-1:0]     div_q;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 busy_q;

  logic [DIV_W-1:0]     div_now;
  logic                 stop_sample;
  logic                 byte_push;
  logic                 frame_set;
  logic                 byte_dropped;
  logic                 fifo_valid;

  assign div_now     = clamp_div(clk_div, DIV_W'(CLK_DIV_MIN));
  // Stop-bit decision point: good stop pushes the byte, low stop is a framing error.
  assign stop_sample = (state == ST_STOP) && (cnt == '0);
  assign byte_push   = stop_sample & rxs;
  assign frame_set   = stop_sample & ~rxs;

  // Two-flop synchroniser for the asynchronous serial line (idles high).
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // Frame sequencer: start-bit qualification, mid-bit data sampling, stop check.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      div_q   <= '0;
      bit_idx <= '0;
      shift   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!rxs) begin
            // Bit period is frozen for the whole frame; wait half a bit to reach mid-start.
            state  <= ST_START;
            div_q  <= div_now;
            cnt    <= div_now >> 1;
            busy_q <= 1'b1;
          end
        end
        ST_START: begin
          if (cnt == '0) begin
            if (!rxs) begin
              state   <= ST_DATA;
              bit_idx <= '0;
              cnt     <= div_q - DIV_W'(1);
            end else begin
              // Line went back high before mid-start: treat as a glitch.
              state  <= ST_IDLE;
              busy_q <= 1'b0;
            end
          end else begin
            cnt <= cnt - DIV_W'(1);
          end
        end
        ST_DATA: begin
          if (cnt == '0) begin
            shift <= {rxs, shift[DATA_BITS-1:1]};
            cnt   <= div_q - DIV_W'(1);
            if (bit_idx == LAST_BIT) begin
              state <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt - DIV_W'(1);
          end
        end
        ST_STOP: begin
          if (cnt == '0) begin
            if (rxs) begin
              state  <= ST_IDLE;
              busy_q <= 1'b0;
            end else begin
              // Stop bit low: park until the line releases so a held-low
              // line is not mistaken for a new start bit.
              state <= ST_BREAK;
            end
          end else begin
            cnt <= cnt - DIV_W'(1);
          end
        end
        ST_BREAK: begin
          if (rxs) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Sticky error flags; a new error event in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      frame_err <= frame_set    | (frame_err & ~err_clr);
      overflow  <= byte_dropped | (overflow  & ~err_clr);
    end
  end

  rx_byte_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clock   (clock),
    .resetb  (resetb),
    .push    (byte_push),
    .wr_data (shift),
    .pop     (rd_en),
    .rd_data (rd_data),
    .valid   (fifo_valid),
    .count   (fifo_count),
    .dropped (byte_dropped)
  );

  assign rd_valid = fifo_valid;
  assign irq      = fifo_valid;
  assign busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : tb_uart_rx_fifo
//  Brief   : Directed plus randomized bench for uart_rx_fifo with a queue
//            based reference model of the FIFO and the sticky flags.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        resetb;
  logic        rx;
  logic [15:0] clk_div;
  logic        rd_en;
  logic        err_clr;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic [3:0]  fifo_count;
  logic        frame_err;
  logic        overflow;
  logic        busy;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  // Reference model: queue of pending bytes plus sticky flags.
  logic [7:0] model_q[$];
  logic       m_ovf;
  logic       m_ferr;

  uart_rx_fifo #(.DEPTH(DEPTH), .CLK_DIV_MIN(4)) dut (
    .clock      (clock),
    .resetb     (resetb),
    .rx         (rx),
    .clk_div    (clk_div),
    .rd_en      (rd_en),
    .err_clr    (err_clr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .fifo_count (fifo_count),
    .frame_err  (frame_err),
    .overflow   (overflow),
    .busy       (busy),
    .irq        (irq)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".count"},    32'(fifo_count), 32'(model_q.size()));
    check({tag, ".rd_valid"}, 32'(rd_valid),   32'(model_q.size() != 0));
    check({tag, ".irq"},      32'(irq),        32'(model_q.size() != 0));
    if (model_q.size() != 0) check({tag, ".rd_data"}, 32'(rd_data), 32'(model_q[0]));
    check({tag, ".overflow"}, 32'(overflow),   32'(m_ovf));
    check({tag, ".frame_err"},32'(frame_err),  32'(m_ferr));
  endtask

  function automatic void model_push(input logic [7:0] b);
    if (model_q.size() < DEPTH) model_q.push_back(b);
    else m_ovf = 1'b1;
  endfunction

  // Drive one 8N1 frame. The receiver decides on the stop bit 3+P/2 cycles
  // into it (2 sync stages, one cycle to leave IDLE, half a bit to mid-start),
  // so an optional rd_en pulse is placed exactly on that push cycle.
  task automatic send(input logic [7:0] b, input logic stop_val, input bit pop_on_push);
    int p;
    p = (clk_div < 16'd4) ? 4 : int'(clk_div);
    rx = 1'b0;
    tick(p);
    for (int k = 0; k < 8; k++) begin
      rx = b[k];
      tick(p);
    end
    rx = stop_val;
    for (int c = 0; c < p + 6; c++) begin
      if (pop_on_push && c == 3 + p / 2) rd_en = 1'b1;
      tick(1);
      rd_en = 1'b0;
    end
  endtask

  task automatic pop_one(input string tag);
    if (model_q.size() != 0) check({tag, ".pop_data"}, 32'(rd_data), 32'(model_q[0]));
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    if (model_q.size() != 0) void'(model_q.pop_front());
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    m_ovf  = 1'b0;
    m_ferr = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    resetb  = 1'b0;
    rx      = 1'b1;
    clk_div = 16'd16;
    rd_en   = 1'b0;
    err_clr = 1'b0;
    m_ovf   = 1'b0;
    m_ferr  = 1'b0;

    // Reset state
    tick(3);
    check("reset.rd_data", 32'(rd_data), 32'h0);
    check("reset.busy",    32'(busy),    32'h0);
    resetb = 1'b1;
    tick(3);
    check_state("reset");
    check("reset.busy_after", 32'(busy), 32'h0);

    // Single byte then pop
    send(8'hA5, 1'b1, 1'b0);
    model_push(8'hA5);
    check_state("t1");
    check("t1.busy", 32'(busy), 32'h0);
    pop_one("t1");
    check_state("t1.after_pop");

    // Overfill: nine bytes into an eight-entry FIFO
    for (int i = 0; i < 9; i++) begin
      send(8'(i), 1'b1, 1'b0);
      model_push(8'(i));
    end
    check_state("t2.full");
    for (int i = 0; i < 8; i++) pop_one("t2");
    check_state("t2.drained");
    pulse_err_clr();
    check_state("t2.cleared");

    // Framing error with line held low, then a clean frame
    send(8'h3C, 1'b0, 1'b0);
    m_ferr = 1'b1;
    tick(40);
    check_state("t3.break");
    check("t3.busy_low", 32'(busy), 32'h1);
    rx = 1'b1;
    tick(4);
    check("t3.busy_released", 32'(busy), 32'h0);
    send(8'h11, 1'b1, 1'b0);
    model_push(8'h11);
    check_state("t3.clean");
    pop_one("t3");
    pulse_err_clr();
    check_state("t3.cleared");

    // Short glitch on the line: no byte, no flag
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(20);
    check("t4.busy", 32'(busy), 32'h0);
    check_state("t4");

    // Reset mid-frame while the FIFO holds a byte
    send(8'h42, 1'b1, 1'b0);
    model_push(8'h42);
    check_state("t5.pre");
    rx = 1'b0;
    tick(16);
    rx = 1'b1;
    tick(16);
    rx = 1'b1;
    tick(10);
    #2 resetb = 1'b0;
    #1;
    model_q.delete();
    check_state("t5.in_reset");
    check("t5.busy",    32'(busy),    32'h0);
    check("t5.rd_data", 32'(rd_data), 32'h0);
    tick(2);
    resetb = 1'b1;
    tick(3);
    send(8'h5A, 1'b1, 1'b0);
    model_push(8'h5A);
    check_state("t5.after");
    pop_one("t5");

    // Bit-period floor plus simultaneous push/pop on a full FIFO
    clk_div = 16'd2;
    tick(2);
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      send(b, 1'b1, 1'b0);
      model_push(b);
    end
    check_state("t6.full");
    check("t6.head_before", 32'(rd_data), 32'(model_q[0]));
    send(8'hC3, 1'b1, 1'b1);
    void'(model_q.pop_front());
    model_push(8'hC3);
    check_state("t6.pushpop");
    check("t6.last", 32'(model_q[DEPTH-1]), 32'hC3);
    for (int i = 0; i < 8; i++) pop_one("t6");
    check_state("t6.drained");

    // Randomized frames with random bit periods and occasional reads
    for (int i = 0; i < 14; i++) begin
      clk_div = 16'($urandom_range(0, 24));
      tick(2);
      b = 8'($urandom);
      send(b, 1'b1, 1'b0);
      model_push(b);
      check_state("rand");
      if ($urandom_range(0, 2) == 0) pop_one("rand");
    end
    while (model_q.size() != 0) pop_one("rand.drain");
    check_state("rand.end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
